// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute bundle: D-stage fields and hazard controls flow into
// the pipeline register, E-stage copies flow out. The perf counters exist
// only when IDEX_PERF_EN is defined.
interface id_ex_pipe_reg_if #(
   parameter int XLEN      = 32,
   parameter int ALUCTRL_W = 4
);
   logic                 StallE;
   logic                 FlushE;
   logic                 ValidD;
   logic                 RegWriteD;
   logic [1:0]           ResultSrcD;
   logic                 MemWriteD;
   logic                 BranchD;
   logic                 JumpD;
   logic                 ALUSrcD;
   logic                 SrcAsrcD;
   logic                 jumpRegD;
   logic [ALUCTRL_W-1:0] ALUControlD;
   logic [2:0]           funct3D;
   logic [XLEN-1:0]      RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
   logic [4:0]           Rs1D, Rs2D, RdD;

   logic                 ValidE;
   logic                 RegWriteE;
   logic [1:0]           ResultSrcE;
   logic                 MemWriteE;
   logic                 BranchE;
   logic                 JumpE;
   logic                 ALUSrcE;
   logic                 SrcAsrcE;
   logic                 jumpRegE;
   logic [ALUCTRL_W-1:0] ALUControlE;
   logic [2:0]           funct3E;
   logic [XLEN-1:0]      RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
   logic [4:0]           Rs1E, Rs2E, RdE;
`ifdef IDEX_PERF_EN
   logic [31:0]          BubbleCntE;
   logic [31:0]          StallCntE;
`endif

   // Decode side / hazard unit: drives D fields and stall/flush.
   modport master (
      output StallE, FlushE, ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD,
             JumpD, ALUSrcD, SrcAsrcD, jumpRegD, ALUControlD, funct3D,
             RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
      input  ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
             ALUSrcE, SrcAsrcE, jumpRegE, ALUControlE, funct3E,
             RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
`ifdef IDEX_PERF_EN
      , input BubbleCntE, StallCntE
`endif
   );

   // Pipeline register side.
   modport slave (
      input  StallE, FlushE, ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD,
             JumpD, ALUSrcD, SrcAsrcD, jumpRegD, ALUControlD, funct3D,
             RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
      output ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
             ALUSrcE, SrcAsrcE, jumpRegE, ALUControlE, funct3E,
             RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
`ifdef IDEX_PERF_EN
      , output BubbleCntE, StallCntE
`endif
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Flush inserts an all-zero bubble (wins over stall), stall holds, otherwise
// the D-stage fields are captured. All outputs come straight from flops.
// Optional macro IDEX_PERF_EN adds saturating bubble/stall edge counters.
module id_ex_pipe_reg #(
   parameter int XLEN      = 32,
   parameter int ALUCTRL_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_pipe_reg_if.slave  bus
);
   typedef struct packed {
      logic                 valid;
      logic                 reg_write;
      logic [1:0]           result_src;
      logic                 mem_write;
      logic                 branch;
      logic                 jump;
      logic                 alu_src;
      logic                 src_a_src;
      logic                 jump_reg;
      logic [ALUCTRL_W-1:0] alu_control;
      logic [2:0]           funct3;
      logic [XLEN-1:0]      rd1;
      logic [XLEN-1:0]      rd2;
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      pc_plus4;
      logic [XLEN-1:0]      imm_ext;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
   } entry_t;

   entry_t entry_in_s;
   entry_t entry_d;
   entry_t entry_q;

   // Gather the D-stage fields into one record.
   always_comb begin
      entry_in_s             = '0;
      entry_in_s.valid       = bus.ValidD;
      entry_in_s.reg_write   = bus.RegWriteD;
      entry_in_s.result_src  = bus.ResultSrcD;
      entry_in_s.mem_write   = bus.MemWriteD;
      entry_in_s.branch      = bus.BranchD;
      entry_in_s.jump        = bus.JumpD;
      entry_in_s.alu_src     = bus.ALUSrcD;
      entry_in_s.src_a_src   = bus.SrcAsrcD;
      entry_in_s.jump_reg    = bus.jumpRegD;
      entry_in_s.alu_control = bus.ALUControlD;
      entry_in_s.funct3      = bus.funct3D;
      entry_in_s.rd1         = bus.RD1D;
      entry_in_s.rd2         = bus.RD2D;
      entry_in_s.pc          = bus.PCD;
      entry_in_s.pc_plus4    = bus.PCPlus4D;
      entry_in_s.imm_ext     = bus.ImmExtD;
      entry_in_s.rs1         = bus.Rs1D;
      entry_in_s.rs2         = bus.Rs2D;
      entry_in_s.rd          = bus.RdD;
   end

   // Next-entry select: flush beats stall, stall beats capture.
   always_comb begin
      entry_d = entry_q;
      if (bus.FlushE) begin
         entry_d = '0;
      end else if (bus.StallE) begin
         entry_d = entry_q;
      end else begin
         entry_d = entry_in_s;
      end
   end

   // E-stage entry register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign bus.ValidE      = entry_q.valid;
   assign bus.RegWriteE   = entry_q.reg_write;
   assign bus.ResultSrcE  = entry_q.result_src;
   assign bus.MemWriteE   = entry_q.mem_write;
   assign bus.BranchE     = entry_q.branch;
   assign bus.JumpE       = entry_q.jump;
   assign bus.ALUSrcE     = entry_q.alu_src;
   assign bus.SrcAsrcE    = entry_q.src_a_src;
   assign bus.jumpRegE    = entry_q.jump_reg;
   assign bus.ALUControlE = entry_q.alu_control;
   assign bus.funct3E     = entry_q.funct3;
   assign bus.RD1E        = entry_q.rd1;
   assign bus.RD2E        = entry_q.rd2;
   assign bus.PCE         = entry_q.pc;
   assign bus.PCPlus4E    = entry_q.pc_plus4;
   assign bus.ImmExtE     = entry_q.imm_ext;
   assign bus.Rs1E        = entry_q.rs1;
   assign bus.Rs2E        = entry_q.rs2;
   assign bus.RdE         = entry_q.rd;

`ifdef IDEX_PERF_EN
   logic [31:0] bubble_cnt_d, bubble_cnt_q;
   logic [31:0] stall_cnt_d, stall_cnt_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Count flush edges and stall-only edges, saturating at all-ones.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (bus.FlushE) begin
         bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else if (bus.StallE) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Counter registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q <= 32'd0;
         stall_cnt_q  <= 32'd0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.BubbleCntE = bubble_cnt_q;
   assign bus.StallCntE  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: each driven cycle pushes the expected
// E-stage record, which is popped and compared one edge later.
module tb_id_ex_pipe_reg;
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [1:0]  result_src;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      logic        src_a_src;
      logic        jump_reg;
      logic [3:0]  alu_control;
      logic [2:0]  funct3;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] imm_ext;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } entry_t;
   localparam int EW = $bits(entry_t);
   typedef logic [EW-1:0] vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   entry_t model_q;
   entry_t exp_q[$];
   int   bub_m;
   int   stl_m;

   id_ex_pipe_reg_if #(.XLEN(32), .ALUCTRL_W(4)) bus ();
   id_ex_pipe_reg #(.XLEN(32), .ALUCTRL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input vec_t obs, input vec_t exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic entry_t dut_entry();
      entry_t o;
      o.valid       = bus.ValidE;
      o.reg_write   = bus.RegWriteE;
      o.result_src  = bus.ResultSrcE;
      o.mem_write   = bus.MemWriteE;
      o.branch      = bus.BranchE;
      o.jump        = bus.JumpE;
      o.alu_src     = bus.ALUSrcE;
      o.src_a_src   = bus.SrcAsrcE;
      o.jump_reg    = bus.jumpRegE;
      o.alu_control = bus.ALUControlE;
      o.funct3      = bus.funct3E;
      o.rd1         = bus.RD1E;
      o.rd2         = bus.RD2E;
      o.pc          = bus.PCE;
      o.pc_plus4    = bus.PCPlus4E;
      o.imm_ext     = bus.ImmExtE;
      o.rs1         = bus.Rs1E;
      o.rs2         = bus.Rs2E;
      o.rd          = bus.RdE;
      return o;
   endfunction

   task automatic set_d(input entry_t e);
      bus.ValidD      = e.valid;
      bus.RegWriteD   = e.reg_write;
      bus.ResultSrcD  = e.result_src;
      bus.MemWriteD   = e.mem_write;
      bus.BranchD     = e.branch;
      bus.JumpD       = e.jump;
      bus.ALUSrcD     = e.alu_src;
      bus.SrcAsrcD    = e.src_a_src;
      bus.jumpRegD    = e.jump_reg;
      bus.ALUControlD = e.alu_control;
      bus.funct3D     = e.funct3;
      bus.RD1D        = e.rd1;
      bus.RD2D        = e.rd2;
      bus.PCD         = e.pc;
      bus.PCPlus4D    = e.pc_plus4;
      bus.ImmExtD     = e.imm_ext;
      bus.Rs1D        = e.rs1;
      bus.Rs2D        = e.rs2;
      bus.RdD         = e.rd;
   endtask

   function automatic entry_t rand_entry();
      vec_t v;
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return entry_t'(v);
   endfunction

   // Drive one cycle at the falling edge, push the expectation, compare after the edge.
   task automatic cycle(input string tag, input logic stall, input logic flush, input entry_t d);
      entry_t exp;
      entry_t got;
      @(negedge clk);
      set_d(d);
      bus.StallE = stall;
      bus.FlushE = flush;
      if (flush) begin
         model_q = '0;
         bub_m++;
      end else if (stall) begin
         stl_m++;
      end else begin
         model_q = d;
      end
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      got = dut_entry();
      exp = exp_q.pop_front();
      check(tag, vec_t'(got), vec_t'(exp));
   endtask

   // Assert reset between edges and check the outputs clear without a clock.
   task automatic mid_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_q = '0;
      bub_m = 0;
      stl_m = 0;
      exp_q.delete();
      check(tag, vec_t'(dut_entry()), vec_t'(model_q));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      entry_t e;
      entry_t busy;
      n_checks = 0;
      n_pass = 0;
      bub_m = 0;
      stl_m = 0;
      model_q = '0;
      busy = rand_entry();
      busy.valid = 1'b1;
      busy.rd = 5'd9;
      set_d(busy);
      bus.StallE = 1'b0;
      bus.FlushE = 1'b0;
      rst_n = 1'b0;
      #3;
      check("reset_initial", vec_t'(dut_entry()), {EW{1'b0}});
      @(posedge clk);
      #1;
      check("reset_held_over_edge", vec_t'(dut_entry()), {EW{1'b0}});
      @(negedge clk);
      rst_n = 1'b1;
      cycle("after_reset_capture", 1'b0, 1'b0, busy);

      // Async reset with nonzero D inputs between edges.
      mid_reset("reset_async");
      cycle("after_reset2_capture", 1'b0, 1'b0, busy);

      // lw pass-through.
      e = '0;
      e.valid = 1'b1;
      e.reg_write = 1'b1;
      e.result_src = 2'b01;
      e.alu_src = 1'b1;
      e.jump_reg = 1'b1;
      e.imm_ext = 32'h10;
      e.rd = 5'd5;
      e.rs1 = 5'd2;
      cycle("lw_pass", 1'b0, 1'b0, e);
      check("lw_rd", vec_t'(bus.RdE), vec_t'(5'd5));
      check("lw_valid", vec_t'(bus.ValidE), vec_t'(1'b1));

      // Stall holds add x3 while D moves on to rd=7.
      e = '0;
      e.valid = 1'b1;
      e.reg_write = 1'b1;
      e.rd = 5'd3;
      e.rd1 = 32'h1111;
      cycle("add_capture", 1'b0, 1'b0, e);
      e.rd = 5'd7;
      e.rd1 = 32'h7777;
      for (int i = 0; i < 3; i++) begin
         cycle("stall_hold", 1'b1, 1'b0, e);
         check("stall_rd", vec_t'(bus.RdE), vec_t'(5'd3));
      end
      cycle("stall_release", 1'b0, 1'b0, e);
      check("release_rd", vec_t'(bus.RdE), vec_t'(5'd7));

      // jal in E, then flushed.
      e = '0;
      e.valid = 1'b1;
      e.jump = 1'b1;
      e.reg_write = 1'b1;
      e.result_src = 2'b10;
      e.rd = 5'd1;
      e.pc = 32'h100;
      cycle("jal_capture", 1'b0, 1'b0, e);
      cycle("jal_flush", 1'b0, 1'b1, e);
      check("flush_jump", vec_t'(bus.JumpE), vec_t'(1'b0));
      check("flush_valid", vec_t'(bus.ValidE), vec_t'(1'b0));

      // sw with flush and stall on the same edge becomes a bubble.
      e = rand_entry();
      e.valid = 1'b1;
      e.mem_write = 1'b1;
      cycle("sw_capture", 1'b0, 1'b0, e);
      cycle("sw_flush_stall", 1'b1, 1'b1, e);
      check("fs_memwrite", vec_t'(bus.MemWriteE), vec_t'(1'b0));

      // ValidD=0 still captures fields verbatim.
      e = rand_entry();
      e.valid = 1'b0;
      cycle("invalid_capture", 1'b0, 1'b0, e);

      // Random mix of capture/stall/flush.
      for (int i = 0; i < 60; i++) begin
         cycle("random", ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), rand_entry());
      end

      // Reset during a stall dominates.
      cycle("pre_stall", 1'b0, 1'b0, busy);
      @(negedge clk);
      bus.StallE = 1'b1;
      mid_reset("reset_mid_stall");
      bus.StallE = 1'b0;

      // Perf sequence: 4 flush, 2 stall-only, 1 flush+stall.
      for (int i = 0; i < 4; i++) cycle("perf_flush", 1'b0, 1'b1, busy);
      for (int i = 0; i < 2; i++) cycle("perf_stall", 1'b1, 1'b0, busy);
      cycle("perf_fs", 1'b1, 1'b1, busy);
`ifdef IDEX_PERF_EN
      check("bubble_cnt", vec_t'(bus.BubbleCntE), vec_t'(32'd5));
      check("stall_cnt", vec_t'(bus.StallCntE), vec_t'(32'd2));
      @(negedge clk);
      force dut.bubble_cnt_q = 32'hFFFF_FFFE;
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.bubble_cnt_q;
      release dut.stall_cnt_q;
      for (int i = 0; i < 3; i++) cycle("sat_flush", 1'b0, 1'b1, busy);
      cycle("sat_stall", 1'b1, 1'b0, busy);
      check("bubble_sat", vec_t'(bus.BubbleCntE), vec_t'(32'hFFFF_FFFF));
      check("stall_sat", vec_t'(bus.StallCntE), vec_t'(32'hFFFF_FFFF));
`endif
      cycle("final_capture", 1'b0, 1'b0, busy);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Sits directly downstream of the main/ALU decoders and register file. Captures every D-stage control and datapath field into its E-stage copy.
- Supports stall (hold), flush (bubble insertion) and a per-stage valid bit.
- The hazard unit drives StallE/FlushE.

Parameters:
XLEN, 32, datapath width
ALUCTRL_W, 4, width of ALUControl bus from ALU decoder

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold E-stage contents
FlushE  in  1  replace E-stage contents with bubble
ValidD  in  1  D-stage holds a real instruction
RegWriteD  in  1  decoded control
ResultSrcD  in  2  decoded control
MemWriteD  in  1  decoded control
BranchD  in  1  decoded control
JumpD  in  1  decoded control
ALUSrcD  in  1  decoded control
SrcAsrcD  in  1  decoded control
jumpRegD  in  1  decoded control
ALUControlD  in  ALUCTRL_W  from ALU decoder
funct3D  in  3  instr[14:12], used for branch compare / load-store size
RD1D, RD2D  in  XLEN  register-file read data
PCD, PCPlus4D, ImmExtD  in  XLEN  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  in  5  register indices
(all of the above have E-suffixed outputs of identical width: RegWriteE ... RdE)
ValidE  out  1  E-stage holds a real instruction

Behaviour:
- Reset: asynchronous on rst_n low. Every E output = 0, ValidE = 0. No clock needed. Release is synchronous to the next rising clk.
- Latency: 1 cycle. An input sampled at edge N appears on outputs after edge N.
- Per rising edge, priority order:
  - FlushE=1: all control outputs (RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUSrcE, SrcAsrcE, jumpRegE, ALUControlE, funct3E) = 0. ValidE = 0. Rs1E/Rs2E/RdE = 0, so forwarding never matches x0. Datapath fields RD1E, RD2E, PCE, PCPlus4E, ImmExtE = 0.
  - else StallE=1: all outputs hold their current value, including ValidE.
  - else: all outputs load their D counterparts. ValidE = ValidD.
- Simultaneous FlushE and StallE: flush wins and a bubble is inserted.
- Bubble semantics: a flushed entry has RegWriteE=MemWriteE=BranchE=JumpE=0, so it cannot change architectural state.
- jumpRegE in a bubble is 0, matching the decoder default for illegal opcodes.
- ValidD=0 with no flush: fields are still captured verbatim and ValidE=0. Downstream stages gate nothing on ValidE; it is informational and used for perf/trace.
- Reset asserted mid-stall or mid-flush: reset dominates immediately.
- No combinational path from any input to any output.

Optional Feature:
- Macro IDEX_PERF_EN.
- When defined, adds two outputs:
  - BubbleCntE (32): counts edges where FlushE=1.
  - StallCntE (32): counts edges where StallE=1 and FlushE=0.
- Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, neither the ports nor the counters exist. Core behaviour is identical in both builds.

Test Plan:
- Reset: drive all D inputs nonzero, pull rst_n low between edges -> all E outputs 0 immediately, ValidE=0. After release and one edge, outputs equal D inputs.
- Pass-through: lw decode (RegWriteD=1, ResultSrcD=01, ALUSrcD=1, jumpRegD=1, ImmExtD=32'h10, RdD=5, ValidD=1) -> next cycle same values on E, ValidE=1.
- Stall: capture add x3 (RdD=3), then StallE=1 for 3 cycles while D changes to RdD=7 -> RdE stays 3 all 3 cycles. Deassert stall -> RdE=7.
- Flush: E holds jal (JumpE=1, RegWriteE=1, ResultSrcE=10), FlushE=1 -> next cycle JumpE=0, RegWriteE=0, ResultSrcE=0, RdE=0, ValidE=0.
- Flush+Stall same edge with sw decoded (MemWriteD=1) -> MemWriteE=0, ValidE=0, i.e. bubble not hold.
- IDEX_PERF_EN: 4 flush edges, 2 stall-only edges, 1 flush+stall edge -> BubbleCntE=5, StallCntE=2. Preload near max via force -> counter sticks at 32'hFFFF_FFFF.
